// File: rtl/debug_dump_pkg.sv
// Shared select codes, strip geometry and FSM encoding for the MIPS debug dump path.
// The debug interface uses the same select codes when it builds a request.
package debug_dump_pkg;

  localparam logic [5:0] NO_REQ         = 6'h3F;
  localparam logic [5:0] SEL_DATA_MEM   = 6'b100000;
  localparam logic [5:0] SEL_INSTR_MEM  = 6'b100001;
  localparam logic [5:0] SEL_PC         = 6'b100010;
  localparam logic [5:0] SEL_FETCH_DATA = 6'b100100;
  localparam logic [5:0] SEL_FETCH_CTRL = 6'b100101;
  localparam logic [5:0] SEL_DECO_DATA  = 6'b100110;
  localparam logic [5:0] SEL_DECO_CTRL  = 6'b100111;
  localparam logic [5:0] SEL_EXEC_DATA  = 6'b101000;
  localparam logic [5:0] SEL_EXEC_CTRL  = 6'b101001;
  localparam logic [5:0] SEL_MEM_DATA   = 6'b101010;
  localparam logic [5:0] SEL_MEM_CTRL   = 6'b101011;

  // Every strip is emitted with the length of the longest one.
  localparam int NB_STRIP_WORDS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

  function automatic logic is_strip(input logic [5:0] sel);
    return (sel >= SEL_FETCH_DATA) && (sel <= SEL_MEM_CTRL);
  endfunction

  // Number of words actually backed by hardware; 0 marks an unknown source.
  function automatic logic [1:0] real_len(input logic [5:0] sel);
    logic [1:0] len;
    len = 2'd0;
    if (!sel[5]) begin
      len = 2'd1;
    end else begin
      case (sel)
        SEL_DATA_MEM, SEL_INSTR_MEM, SEL_PC: len = 2'd1;
        SEL_FETCH_DATA: len = 2'd2;
        SEL_FETCH_CTRL: len = 2'd1;
        SEL_DECO_DATA:  len = 2'd3;
        SEL_DECO_CTRL:  len = 2'd1;
        SEL_EXEC_DATA:  len = 2'd3;
        SEL_EXEC_CTRL:  len = 2'd1;
        SEL_MEM_DATA:   len = 2'd2;
        SEL_MEM_CTRL:   len = 2'd1;
        default:        len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/debug_dump_sequencer.sv
// Walks one debug source word by word through the shared read mux and frames each word,
// closing the transfer with a single end-of-data pulse.
module debug_dump_sequencer
  import debug_dump_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_SEL      = 6,
  parameter int SRC_LATENCY = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NB_SEL-1:0] i_request_select,
  input  logic [NB_REG-1:0] i_src_data,
  output logic [NB_SEL-1:0] o_src_id,
  output logic [1:0]        o_word_idx,
  output logic              o_rd_en,
  output logic [NB_REG-1:0] o_frame,
  output logic              o_frame_valid,
  output logic              o_eod,
  output logic              o_busy,
  output logic              o_req_dropped
);

  localparam int LAT_W = (SRC_LATENCY > 1) ? $clog2(SRC_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRC_LATENCY - 1);
  localparam logic [1:0] STRIP_LAST = 2'(NB_STRIP_WORDS - 1);

  state_t           state, state_next;
  logic [1:0]       word_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       len;
  logic [1:0]       last_idx;
  logic             word_real;
  logic             lat_done;
  logic             accept;

  assign len       = real_len(o_src_id);
  assign last_idx  = is_strip(o_src_id) ? STRIP_LAST : 2'd0;
  assign word_real = word_cnt < len;
  assign lat_done  = lat_cnt == LAT_LAST;
  assign accept    = i_start && (i_request_select != NO_REQ);
  assign o_word_idx = word_cnt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      o_src_id      <= NO_REQ;
      word_cnt      <= 2'd0;
      lat_cnt       <= '0;
      o_frame       <= '0;
      o_req_dropped <= 1'b0;
    end else begin
      state         <= state_next;
      o_req_dropped <= i_start && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_src_id <= i_request_select;
            word_cnt <= 2'd0;
          end
        end
        ST_READ: lat_cnt <= '0;
        ST_WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          // Padding words never touched the mux, so they are forced to zero here.
          if (lat_done) o_frame <= word_real ? i_src_data : '0;
        end
        ST_EMIT: begin
          if (word_cnt != last_idx) word_cnt <= word_cnt + 2'd1;
        end
        ST_DONE: o_src_id <= NO_REQ;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    o_rd_en       = 1'b0;
    o_frame_valid = 1'b0;
    o_eod         = 1'b0;
    o_busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (accept) state_next = ST_READ;
      ST_READ: begin
        o_rd_en    = word_real;
        // Unknown sources produce no frames, only the closing EoD.
        state_next = (len == 2'd0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: if (lat_done) state_next = ST_EMIT;
      ST_EMIT: begin
        o_frame_valid = 1'b1;
        state_next    = (word_cnt == last_idx) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        o_eod      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: one instance at read latency 1, one at latency 3,
// with a behavioural read mux that only presents data exactly SRC_LATENCY cycles after o_rd_en.
module tb_debug_dump_sequencer;
  import debug_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, b_start;
  logic [5:0]  a_sel, b_sel;
  logic [31:0] a_src, b_src;
  logic [5:0]  a_id, b_id;
  logic [1:0]  a_idx, b_idx;
  logic        a_rd, b_rd, a_valid, b_valid, a_eod, b_eod, a_busy, b_busy, a_drop, b_drop;
  logic [31:0] a_frame, b_frame;

  logic [31:0] tab [0:3];
  logic [2:0]  a_sh = 3'b000;
  logic [2:0]  b_sh = 3'b000;

  int n_vec = 0;
  int n_err = 0;

  debug_dump_sequencer #(.NB_REG(32), .NB_SEL(6), .SRC_LATENCY(1)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(a_start), .i_request_select(a_sel),
    .i_src_data(a_src), .o_src_id(a_id), .o_word_idx(a_idx), .o_rd_en(a_rd),
    .o_frame(a_frame), .o_frame_valid(a_valid), .o_eod(a_eod), .o_busy(a_busy),
    .o_req_dropped(a_drop)
  );

  debug_dump_sequencer #(.NB_REG(32), .NB_SEL(6), .SRC_LATENCY(3)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(b_start), .i_request_select(b_sel),
    .i_src_data(b_src), .o_src_id(b_id), .o_word_idx(b_idx), .o_rd_en(b_rd),
    .o_frame(b_frame), .o_frame_valid(b_valid), .o_eod(b_eod), .o_busy(b_busy),
    .o_req_dropped(b_drop)
  );

  // Read mux model: data is only valid in the cycle that ends the last WAIT cycle.
  always @(posedge clk) begin
    a_sh <= {a_sh[1:0], a_rd};
    b_sh <= {b_sh[1:0], b_rd};
  end
  assign a_src = a_sh[0] ? tab[a_idx] : 32'hBAD0_BAD0;
  assign b_src = b_sh[2] ? tab[b_idx] : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input bit inst, input logic [5:0] sel);
    @(negedge clk);
    if (inst) begin b_start = 1'b1; b_sel = sel; end
    else      begin a_start = 1'b1; a_sel = sel; end
    @(negedge clk);
    a_start = 1'b0; a_sel = NO_REQ;
    b_start = 1'b0; b_sel = NO_REQ;
  endtask

  // Called at the negedge of cycle 1 (first cycle after the start edge).
  task automatic check_xfer(input bit inst, input string name, input int nw, input int lat,
                            input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                            input logic [2:0] rd_mask, input int inject);
    logic [31:0] fr [0:2];
    int p, eodc;
    logic exp_rd, exp_v, chk_idx;
    logic [31:0] exp_f;
    logic [1:0] exp_idx;
    fr[0] = f0; fr[1] = f1; fr[2] = f2;
    p = lat + 2;
    eodc = (nw == 0) ? 2 : nw * p + 1;
    for (int c = 1; c <= eodc + 1; c++) begin
      exp_rd = 1'b0; exp_v = 1'b0; exp_f = '0; exp_idx = 2'd0; chk_idx = 1'b0;
      for (int k = 0; k < nw; k++) begin
        if (c == 1 + k * p) begin exp_rd = rd_mask[k]; exp_idx = 2'(k); chk_idx = 1'b1; end
        if (c == (k + 1) * p) begin exp_v = 1'b1; exp_f = fr[k]; end
      end
      chk($sformatf("%s_c%0d_valid", name, c), inst ? b_valid : a_valid, 32'(exp_v));
      chk($sformatf("%s_c%0d_rd_en", name, c), inst ? b_rd : a_rd, 32'(exp_rd));
      chk($sformatf("%s_c%0d_eod", name, c), inst ? b_eod : a_eod, 32'(c == eodc));
      chk($sformatf("%s_c%0d_busy", name, c), inst ? b_busy : a_busy, 32'(c <= eodc));
      chk($sformatf("%s_c%0d_drop", name, c), inst ? b_drop : a_drop, 32'(c == inject + 1));
      if (exp_v) chk($sformatf("%s_c%0d_frame", name, c), inst ? b_frame : a_frame, exp_f);
      if (chk_idx) chk($sformatf("%s_c%0d_idx", name, c), inst ? b_idx : a_idx, 32'(exp_idx));
      if (!inst) begin
        a_start = (c == inject);
        a_sel   = (c == inject) ? SEL_DECO_DATA : NO_REQ;
      end
      @(negedge clk);
    end
    a_start = 1'b0; a_sel = NO_REQ;
    chk({name, "_idle_src"}, inst ? b_id : a_id, 32'(NO_REQ));
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_sel = NO_REQ;
    b_start = 1'b0; b_sel = NO_REQ;
    for (int i = 0; i < 4; i++) tab[i] = '0;
    repeat (2) @(negedge clk);

    chk("rst_src_id", a_id, 32'(NO_REQ));
    chk("rst_idx", a_idx, 0);
    chk("rst_frame", a_frame, 0);
    chk("rst_flags", {a_rd, a_valid, a_eod, a_busy, a_drop}, 0);
    chk("rst_b_flags", {b_rd, b_valid, b_eod, b_busy, b_drop}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Register 5, single word
    tab[0] = 32'hDEAD_BEEF;
    start_req(1'b0, 6'b000101);
    check_xfer(1'b0, "reg5", 1, 1, 32'hDEAD_BEEF, 0, 0, 3'b001, -10);
    chk("reg5_hold", a_frame, 32'hDEAD_BEEF);

    // DECO_DATA strip, three real words
    tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33;
    start_req(1'b0, SEL_DECO_DATA);
    check_xfer(1'b0, "deco", 3, 1, 32'h11, 32'h22, 32'h33, 3'b111, -10);

    // FETCH_CTRL strip, one real word then zero padding
    tab[0] = 32'hAA; tab[1] = 32'h55; tab[2] = 32'h66;
    start_req(1'b0, SEL_FETCH_CTRL);
    check_xfer(1'b0, "fctrl", 3, 1, 32'hAA, 0, 0, 3'b001, -10);

    // Start while busy is dropped; transfer continues unchanged
    tab[0] = 32'h1234_5678;
    start_req(1'b0, 6'b000101);
    check_xfer(1'b0, "drop", 1, 1, 32'h1234_5678, 0, 0, 3'b001, 2);

    // No-request select at idle does nothing
    @(negedge clk);
    a_start = 1'b1; a_sel = NO_REQ;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("noreq_c%0d_flags", c), {a_rd, a_valid, a_eod, a_busy, a_drop}, 0);
      chk($sformatf("noreq_c%0d_src", c), a_id, 32'(NO_REQ));
      @(negedge clk);
    end

    // Unlisted id: zero frames, EoD in cycle 2
    start_req(1'b0, 6'b101111);
    check_xfer(1'b0, "unlisted", 0, 1, 0, 0, 0, 3'b000, -10);

    // Reset during WAIT of word 1
    tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33;
    start_req(1'b0, SEL_DECO_DATA);
    repeat (4) @(negedge clk);
    chk("prerst_idx", a_idx, 1);
    chk("prerst_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_src", a_id, 32'(NO_REQ));
    chk("midrst_idx", a_idx, 0);
    chk("midrst_frame", a_frame, 0);
    chk("midrst_flags", {a_rd, a_valid, a_eod, a_busy, a_drop}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("postrst_c%0d_flags", c), {a_rd, a_valid, a_eod, a_busy, a_drop}, 0);
      @(negedge clk);
    end
    tab[0] = 32'hCAFE_F00D;
    start_req(1'b0, 6'b011111);
    check_xfer(1'b0, "postrst", 1, 1, 32'hCAFE_F00D, 0, 0, 3'b001, -10);

    // Latency-3 instance: 5-cycle word spacing, data valid only 3 cycles after rd_en
    tab[0] = 32'hA1; tab[1] = 32'hB2; tab[2] = 32'hC3;
    start_req(1'b1, SEL_EXEC_DATA);
    check_xfer(1'b1, "lat3", 3, 3, 32'hA1, 32'hB2, 32'hC3, 3'b111, -10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
